bcd_convert_seq: RTL and testbench

Sequencer that converts a 14-bit binary value to four BCD digits for the seven-segment display by driving the shared `divide10` unit repeatedly. Each pass divides by 10, keeps the remainder as the next digit (LSD first) and feeds the quotient back as the next dividend. It sits between the value source (counter/user logic) and the display multiplexer. It owns the divider's `start`/`dividend` inputs exclusively.

---
 rtl/bcd_convert_seq_if.sv | 24 ++
 rtl/bcd_convert_seq.sv | 162 ++++++++++++++++
 tb/tb_bcd_convert_seq.sv | 301 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/bcd_convert_seq_if.sv
// Divider handshake bundle between bcd_convert_seq (master) and divide10 (slave).
interface bcd_convert_seq_if;
  logic        div_start;
  logic [13:0] div_dividend;
  logic [9:0]  div_quotient;
  logic [13:0] div_remainder;
  logic        div_done;

  modport master (
    output div_start,
    output div_dividend,
    input  div_quotient,
    input  div_remainder,
    input  div_done
  );

  modport slave (
    input  div_start,
    input  div_dividend,
    output div_quotient,
    output div_remainder,
    output div_done
  );
endinterface

// File: rtl/bcd_convert_seq.sv
// bcd_convert_seq: converts a 14-bit binary value into four BCD digits by
// running the shared divide10 unit repeatedly (LSD first).
// Optional feature macro: BCD_BLANK_LEADING_EN -- leading zero digits above the
// most significant nonzero digit are shown as 4'hF (blank); units never blanked.
module bcd_convert_seq #(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  input  logic [13:0]              in_value,
  output logic                     in_ready,
  bcd_convert_seq_if.master        div,
  output logic [15:0]              bcd,
  output logic                     out_valid,
  output logic                     ovf,
  output logic                     err
);

  localparam int unsigned TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DIV,
    S_GAP,
    S_OUT
  } state_e;

  state_e            state_q, state_d;
  logic [13:0]       dividend_q, dividend_d;
  logic [1:0]        idx_q, idx_d;
  logic [3:0][3:0]   digits_q, digits_d;
  logic [TW-1:0]     tmo_q, tmo_d;
  logic [15:0]       bcd_q, bcd_d;
  logic              ovf_q, ovf_d;
  logic              err_q, err_d;

  logic [3:0][3:0]   merged;
  logic [3:0][3:0]   result;
  logic              unused_rem;

  // Upper remainder bits are never meaningful for a divide-by-10.
  assign unused_rem = ^div.div_remainder[13:4];

  // Scratch digits with the current remainder inserted and higher digits zero-filled.
  always_comb begin
    merged = digits_q;
    merged[idx_q] = div.div_remainder[3:0];
    for (int unsigned i = 0; i < 4; i++) begin
      if (2'(i) > idx_q) merged[2'(i)] = '0;
    end
  end

  // Final display formatting of the assembled digits.
  always_comb begin
    result = merged;
`ifdef BCD_BLANK_LEADING_EN
    begin
      logic lead;
      lead = 1'b1;
      for (int unsigned i = 0; i < 3; i++) begin
        if (lead && (merged[2'(3 - i)] == 4'h0)) begin
          result[2'(3 - i)] = 4'hF;
        end else begin
          lead = 1'b0;
        end
      end
    end
`endif
  end

  // Next-state and datapath updates for the conversion sequencer.
  always_comb begin
    state_d    = state_q;
    dividend_d = dividend_q;
    idx_d      = idx_q;
    digits_d   = digits_q;
    tmo_d      = tmo_q;
    bcd_d      = bcd_q;
    ovf_d      = ovf_q;
    err_d      = err_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          if (in_value > 14'd9999) begin
            bcd_d   = 16'h9999;
            ovf_d   = 1'b1;
            err_d   = 1'b0;
            state_d = S_OUT;
          end else begin
            dividend_d = in_value;
            idx_d      = '0;
            digits_d   = '0;
            tmo_d      = '0;
            state_d    = S_DIV;
          end
        end
      end
      S_DIV: begin
        if (div.div_done) begin
          digits_d = merged;
          if ((idx_q == 2'd3) || (div.div_quotient == 10'd0)) begin
            bcd_d   = result;
            ovf_d   = 1'b0;
            err_d   = 1'b0;
            state_d = S_OUT;
          end else begin
            idx_d      = idx_q + 2'd1;
            dividend_d = {4'b0, div.div_quotient};
            state_d    = S_GAP;
          end
        end else if (tmo_q == TW'(TIMEOUT - 1)) begin
          err_d   = 1'b1;
          ovf_d   = 1'b0;
          state_d = S_OUT;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      S_GAP: begin
        tmo_d   = '0;
        state_d = S_DIV;
      end
      S_OUT: begin
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      dividend_q <= '0;
      idx_q      <= '0;
      digits_q   <= '0;
      tmo_q      <= '0;
      bcd_q      <= '0;
      ovf_q      <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      dividend_q <= dividend_d;
      idx_q      <= idx_d;
      digits_q   <= digits_d;
      tmo_q      <= tmo_d;
      bcd_q      <= bcd_d;
      ovf_q      <= ovf_d;
      err_q      <= err_d;
    end
  end

  assign in_ready         = (state_q == S_IDLE);
  assign out_valid        = (state_q == S_OUT);
  assign div.div_start    = (state_q == S_DIV);
  assign div.div_dividend = dividend_q;
  assign bcd              = bcd_q;
  assign ovf              = ovf_q;
  assign err              = err_q;

endmodule

// File: tb/tb_bcd_convert_seq.sv
// Testbench for bcd_convert_seq with a behavioural divide10 model of
// programmable latency; table vectors, corner sequences and random values.
module tb_bcd_convert_seq;

`ifdef BCD_BLANK_LEADING_EN
  localparam bit BLANK = 1'b1;
`else
  localparam bit BLANK = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [13:0] in_value;
  logic        in_ready;
  logic [15:0] bcd;
  logic        out_valid;
  logic        ovf;
  logic        err;

  always #5 clk = ~clk;

  bcd_convert_seq_if dbus ();

  bcd_convert_seq #(.TIMEOUT(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_value  (in_value),
    .in_ready  (in_ready),
    .div       (dbus),
    .bcd       (bcd),
    .out_valid (out_valid),
    .ovf       (ovf),
    .err       (err)
  );

  // divide10 model: done asserted in the lat-th cycle of start being high.
  int lat  = 3;
  bit hang = 1'b0;
  int cnt  = 0;

  always @(posedge clk) begin
    if (!dbus.div_start) cnt <= 0;
    else                 cnt <= cnt + 1;
  end

  assign dbus.div_done      = dbus.div_start && !hang && (cnt == lat - 1);
  assign dbus.div_quotient  = 10'(dbus.div_dividend / 14'd10);
  assign dbus.div_remainder = dbus.div_dividend % 14'd10;

  int vecs    = 0;
  int miscmp  = 0;

  bit          sh [0:255];
  logic [13:0] dh [0:255];
  int          nout;
  logic [15:0] last_exp;

  typedef struct {
    int          value;
    logic [15:0] exp_bcd;
    bit          exp_ovf;
    int          exp_k;
  } vec_t;

  vec_t tbl [12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      miscmp++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] ref_bcd(input int v);
    int d [4];
    logic [15:0] r;
    bit lead;
    if (v > 9999) return 16'h9999;
    for (int i = 0; i < 4; i++) begin
      d[i] = v % 10;
      v = v / 10;
    end
    for (int i = 0; i < 4; i++) r[i*4 +: 4] = 4'(d[i]);
    if (BLANK) begin
      lead = 1'b1;
      for (int i = 3; i >= 1; i--) begin
        if (lead && d[i] == 0) r[i*4 +: 4] = 4'hF;
        else lead = 1'b0;
      end
    end
    return r;
  endfunction

  function automatic int ref_k(input int v);
    int k;
    if (v > 9999) return 0;
    k = 1;
    while (v >= 10) begin
      v = v / 10;
      k++;
    end
    return k;
  endfunction

  // Offer one value, record start/dividend per cycle until out_valid.
  task automatic convert(input logic [13:0] v, input bit poke);
    int busy_bad;
    @(negedge clk);
    chk("in_ready_idle", 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    in_value = v;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    in_value = '0;
    nout     = 0;
    busy_bad = 0;
    for (int n = 1; n < 256 && nout == 0; n++) begin
      if (n > 1) @(negedge clk);
      sh[n] = dbus.div_start;
      dh[n] = dbus.div_dividend;
      if (out_valid) nout = n;
      else if (in_ready) busy_bad++;
      if (poke) begin
        if (n == 2) begin
          in_valid = 1'b1;
          in_value = 14'd777;
        end else if (n == 3) begin
          in_valid = 1'b0;
          in_value = '0;
        end
      end
    end
    in_valid = 1'b0;
    if (nout == 0) begin
      vecs++;
      miscmp++;
      $display("FAIL out_valid_wait: got no pulse expected pulse within 255 cycles");
    end
    chk("in_ready_busy", 32'(busy_bad), 32'd0);
  endtask

  // Expected start pattern: k runs of lat cycles separated by one low cycle.
  task automatic check_seq(input int v, input int l, input int k);
    bit   es  [0:255];
    int   edv [0:255];
    int   base, dv, exp_out, sbad, dbad;
    for (int i = 0; i < 256; i++) begin
      es[i]  = 1'b0;
      edv[i] = 0;
    end
    base = 1;
    dv   = v;
    for (int j = 0; j < k; j++) begin
      for (int t = 0; t < l; t++) begin
        es[base + t]  = 1'b1;
        edv[base + t] = dv;
      end
      base = base + l + 1;
      dv   = dv / 10;
    end
    exp_out = (k == 0) ? 1 : base - 1;
    chk("out_cycle", 32'(nout), 32'(exp_out));
    sbad = 0;
    dbad = 0;
    for (int n = 1; n <= nout; n++) begin
      if (sh[n] != es[n]) sbad++;
      if (es[n] && (int'(dh[n]) != edv[n])) dbad++;
    end
    chk("start_pattern", 32'(sbad), 32'd0);
    chk("dividend_seq", 32'(dbad), 32'd0);
  endtask

  // One cycle after out_valid: pulse gone and block ready again.
  task automatic post();
    @(negedge clk);
    chk("out_valid_pulse", 32'(out_valid), 32'd0);
    chk("in_ready_after", 32'(in_ready), 32'd1);
  endtask

  initial begin
    tbl[0]  = '{6,     BLANK ? 16'hFFF6 : 16'h0006, 1'b0, 1};
    tbl[1]  = '{9999,  16'h9999,                    1'b0, 4};
    tbl[2]  = '{10000, 16'h9999,                    1'b1, 0};
    tbl[3]  = '{305,   BLANK ? 16'hF305 : 16'h0305, 1'b0, 3};
    tbl[4]  = '{0,     BLANK ? 16'hFFF0 : 16'h0000, 1'b0, 1};
    tbl[5]  = '{42,    BLANK ? 16'hFF42 : 16'h0042, 1'b0, 2};
    tbl[6]  = '{70,    BLANK ? 16'hFF70 : 16'h0070, 1'b0, 2};
    tbl[7]  = '{1234,  16'h1234,                    1'b0, 4};
    tbl[8]  = '{16383, 16'h9999,                    1'b1, 0};
    tbl[9]  = '{10,    BLANK ? 16'hFF10 : 16'h0010, 1'b0, 2};
    tbl[10] = '{100,   BLANK ? 16'hF100 : 16'h0100, 1'b0, 3};
    tbl[11] = '{1000,  16'h1000,                    1'b0, 4};

    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_value = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_div_start", 32'(dbus.div_start), 32'd0);
    chk("rst_dividend", 32'(dbus.div_dividend), 32'd0);
    chk("rst_bcd", 32'(bcd), 32'h0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    rst_n = 1'b1;

    // Table vectors, divider latency 3.
    lat = 3;
    for (int i = 0; i < 12; i++) begin
      convert(14'(tbl[i].value), 1'b0);
      chk($sformatf("tbl%0d_bcd", i), 32'(bcd), 32'(tbl[i].exp_bcd));
      chk($sformatf("tbl%0d_ovf", i), 32'(ovf), 32'(tbl[i].exp_ovf));
      chk($sformatf("tbl%0d_err", i), 32'(err), 32'd0);
      check_seq(tbl[i].value, 3, tbl[i].exp_k);
      post();
    end

    // in_valid pulsed while busy must be ignored.
    convert(14'd42, 1'b1);
    chk("poke_bcd", 32'(bcd), 32'(ref_bcd(42)));
    check_seq(42, 3, 2);
    post();
    last_exp = ref_bcd(42);
    begin
      int extra;
      extra = 0;
      repeat (3) begin
        @(negedge clk);
        if (dbus.div_start || out_valid || !in_ready) extra++;
      end
      chk("poke_ignored", 32'(extra), 32'd0);
    end

    // Divider never answers: abort after 8 DIV cycles, bcd unchanged.
    hang = 1'b1;
    convert(14'd57, 1'b0);
    chk("tmo_out_cycle", 32'(nout), 32'd9);
    begin
      int sbad;
      sbad = 0;
      for (int n = 1; n <= nout; n++) begin
        if (sh[n] != (n <= 8)) sbad++;
      end
      chk("tmo_start_pattern", 32'(sbad), 32'd0);
    end
    chk("tmo_err", 32'(err), 32'd1);
    chk("tmo_ovf", 32'(ovf), 32'd0);
    chk("tmo_bcd_kept", 32'(bcd), 32'(last_exp));
    post();
    hang = 1'b0;
    convert(14'd305, 1'b0);
    chk("after_tmo_bcd", 32'(bcd), 32'(ref_bcd(305)));
    chk("after_tmo_err", 32'(err), 32'd0);
    post();

    // Reset during the second division of 1234.
    @(negedge clk);
    in_valid = 1'b1;
    in_value = 14'd1234;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (5) @(negedge clk);
    chk("mid_div_start", 32'(dbus.div_start), 32'd1);
    chk("mid_dividend", 32'(dbus.div_dividend), 32'd123);
    rst_n = 1'b0;
    @(negedge clk);
    chk("rst_mid_start", 32'(dbus.div_start), 32'd0);
    chk("rst_mid_bcd", 32'(bcd), 32'h0);
    chk("rst_mid_ready", 32'(in_ready), 32'd1);
    chk("rst_mid_out_valid", 32'(out_valid), 32'd0);
    rst_n = 1'b1;
    convert(14'd1234, 1'b0);
    chk("after_rst_bcd", 32'(bcd), 32'h1234);
    check_seq(1234, 3, 4);
    post();

    // Random values against the reference model, random divider latency.
    for (int r = 0; r < 60; r++) begin
      int v;
      v = int'($urandom_range(0, 16383));
      if ($urandom_range(0, 3) == 0) v = int'($urandom_range(0, 99));
      lat = int'($urandom_range(1, 6));
      convert(14'(v), 1'b0);
      chk($sformatf("rnd%0d_bcd(v=%0d)", r, v), 32'(bcd), 32'(ref_bcd(v)));
      chk($sformatf("rnd%0d_ovf", r), 32'(ovf), 32'(v > 9999));
      chk($sformatf("rnd%0d_err", r), 32'(err), 32'd0);
      check_seq(v, lat, ref_k(v));
      post();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, miscmp);
    $finish;
  end

endmodule
